// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: field widths, FU tag codes and the bus payload structs.
// The tag is {FU tag, RS one-hot}; FU tag 0 is reserved to mean "no producer".
package cdb_arbiter_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned TAG_W    = 8;
  localparam int unsigned FU_TAG_W = 5;
  localparam int unsigned RS_W     = 3;

  localparam logic [FU_TAG_W-1:0] FU_NONE_TAG = 5'd0;
  localparam logic [FU_TAG_W-1:0] FU_LS_TAG   = 5'd1;
  localparam logic [FU_TAG_W-1:0] FU_ALU_TAG  = 5'd2;
  localparam logic [FU_TAG_W-1:0] FU_MUL_TAG  = 5'd3;
  localparam logic [FU_TAG_W-1:0] FU_DIV_TAG  = 5'd4;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } tagged_data_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_bus_t;

  function automatic logic [FU_TAG_W-1:0] fu_tag_of(input logic [TAG_W-1:0] tag);
    return tag[TAG_W-1:RS_W];
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping at N.
// The wrap is an explicit compare so non-power-of-2 N never aliases past N-1.
module cdb_arbiter_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] win_idx_o,
  output logic          any_o
);

  always_comb begin : pick_p
    int unsigned j;
    logic        found;
    j         = 0;
    found     = 1'b0;
    win_idx_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = k + 32'(ptr_i);
      if (j >= N) begin
        j = j - N;
      end
      if (!found && req_i[PW'(j)]) begin
        found     = 1'b1;
        win_idx_o = PW'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: grants one ready FU result per cycle onto the registered CDB,
// round-robin between sources, and counts busy bus cycles (saturating).
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [NUM_SRC-1:0]   req_i,
  input  tagged_data_t         src_data_i [NUM_SRC],
  output cdb_bus_t             cdb_o,
  output logic [NUM_SRC-1:0]   grant_o,
  output logic [CNT_W-1:0]     busy_cnt_o
);

  localparam int unsigned PTR_W = $clog2(NUM_SRC);
  localparam logic [NUM_SRC-1:0] GRANT_LSB = NUM_SRC'(1);
  localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(NUM_SRC - 1);

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  cdb_bus_t           cdb_q, cdb_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PTR_W-1:0]   win_idx;
  logic               any_req;

  cdb_arbiter_rr_pick #(
    .N  (NUM_SRC),
    .PW (PTR_W)
  ) u_rr_pick (
    .req_i     (req_i),
    .ptr_i     (ptr_q),
    .win_idx_o (win_idx),
    .any_o     (any_req)
  );

  // Flush or an idle cycle leaves the bus empty and keeps pointer/counter.
  always_comb begin
    cdb_d   = '0;
    grant_d = '0;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (!flush && any_req) begin
      cdb_d.valid = 1'b1;
      cdb_d.tag   = src_data_i[win_idx].tag;
      cdb_d.data  = src_data_i[win_idx].val;
      grant_d     = GRANT_LSB << win_idx;
      ptr_d       = (win_idx == PTR_LAST) ? '0 : win_idx + PTR_W'(1);
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      cdb_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      cdb_q   <= cdb_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cdb_o      = cdb_q;
  assign grant_o    = grant_q;
  assign busy_cnt_o = cnt_q;

  grant_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  grant_valid_a:  assert property (@(posedge clk) disable iff (rst)
                                   ((grant_q != '0) == cdb_q.valid));

  // FU tag 0 means "no producer" and must never be offered to the bus.
  for (genvar i = 0; i < int'(NUM_SRC); i++) begin : g_tag_chk
    tag_nonzero_a: assert property (@(posedge clk) disable iff (rst)
                                    req_i[i] |-> (fu_tag_of(src_data_i[i].tag) != FU_NONE_TAG));
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a 4-source/32-bit-counter instance and a 3-source/3-bit-counter
// instance, checked against a queue-free round-robin reference model and a vector table.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  typedef struct {
    logic [3:0]  req;
    logic        fl;
    logic [3:0]  gnt;
    logic [31:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush;

  logic [3:0]   req4;
  tagged_data_t data4 [4];
  cdb_bus_t     cdb4;
  logic [3:0]   grant4;
  logic [31:0]  cnt4;

  logic [2:0]   req3;
  tagged_data_t data3 [3];
  cdb_bus_t     cdb3;
  logic [2:0]   grant3;
  logic [2:0]   cnt3;

  int total = 0;
  int bad   = 0;

  int     mptr4, mptr3, mcnt3;
  longint mcnt4;
  logic        e4_v, e3_v;
  logic [7:0]  e4_tag, e3_tag;
  logic [31:0] e4_dat, e3_dat;
  logic [3:0]  e4_g;
  logic [2:0]  e3_g;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_SRC(4), .CNT_W(32)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .req_i(req4), .src_data_i(data4),
    .cdb_o(cdb4), .grant_o(grant4), .busy_cnt_o(cnt4)
  );

  cdb_arbiter #(.NUM_SRC(3), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .flush(flush), .req_i(req3), .src_data_i(data3),
    .cdb_o(cdb3), .grant_o(grant3), .busy_cnt_o(cnt3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference pick: scan ptr, ptr+1, ... modulo n.
  function automatic int pick(input int mask, input int ptr, input int n);
    for (int k = 0; k < n; k++) begin
      int j;
      j = (ptr + k) % n;
      if (mask[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [7:0] rand_tag();
    logic [4:0] fu;
    logic [2:0] rs;
    fu = 5'($urandom_range(31, 1));
    rs = 3'(1 << $urandom_range(2, 0));
    return {fu, rs};
  endfunction

  task automatic model_reset();
    mptr4 = 0; mcnt4 = 0; e4_v = 0; e4_tag = '0; e4_dat = '0; e4_g = '0;
    mptr3 = 0; mcnt3 = 0; e3_v = 0; e3_tag = '0; e3_dat = '0; e3_g = '0;
  endtask

  task automatic check_all(input string sfx);
    check({"cdb4", sfx},   64'(cdb4),   64'({e4_v, e4_tag, e4_dat}));
    check({"grant4", sfx}, 64'(grant4), 64'(e4_g));
    check({"cnt4", sfx},   64'(cnt4),   64'(mcnt4));
    check({"cdb3", sfx},   64'(cdb3),   64'({e3_v, e3_tag, e3_dat}));
    check({"grant3", sfx}, 64'(grant3), 64'(e3_g));
    check({"cnt3", sfx},   64'(cnt3),   64'(mcnt3));
  endtask

  // One clock: advance the model on the inputs present at the edge, then compare.
  task automatic tick();
    int w;
    @(posedge clk);
    w = flush ? -1 : pick(int'(req4), mptr4, 4);
    if (w < 0) begin
      e4_v = 0; e4_tag = '0; e4_dat = '0; e4_g = '0;
    end else begin
      e4_v = 1; e4_tag = data4[w].tag; e4_dat = data4[w].val; e4_g = 4'(1 << w);
      mptr4 = (w + 1) % 4;
      if (mcnt4 < 64'hFFFF_FFFF) mcnt4++;
    end
    w = flush ? -1 : pick(int'(req3), mptr3, 3);
    if (w < 0) begin
      e3_v = 0; e3_tag = '0; e3_dat = '0; e3_g = '0;
    end else begin
      e3_v = 1; e3_tag = data3[w].tag; e3_dat = data3[w].val; e3_g = 3'(1 << w);
      mptr3 = (w + 1) % 3;
      if (mcnt3 < 7) mcnt3++;
    end
    #1;
    check_all("");
  endtask

  // Asynchronous reset, checked before any clock edge can occur.
  task automatic do_reset();
    rst = 1'b1; req4 = '0; req3 = '0; flush = 1'b0;
    #2;
    model_reset();
    check_all("_rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vec_t        vecs [17];
    logic [2:0]  g3 [8];
    logic [7:0]  ls_tags [3];

    vecs[0]  = '{4'hF, 1'b0, 4'h1, 32'd1};
    vecs[1]  = '{4'hF, 1'b0, 4'h2, 32'd2};
    vecs[2]  = '{4'hF, 1'b0, 4'h4, 32'd3};
    vecs[3]  = '{4'hF, 1'b0, 4'h8, 32'd4};
    vecs[4]  = '{4'hF, 1'b0, 4'h1, 32'd5};
    vecs[5]  = '{4'hF, 1'b0, 4'h2, 32'd6};
    vecs[6]  = '{4'hF, 1'b0, 4'h4, 32'd7};
    vecs[7]  = '{4'hF, 1'b0, 4'h8, 32'd8};
    vecs[8]  = '{4'h0, 1'b0, 4'h0, 32'd8};
    vecs[9]  = '{4'h2, 1'b1, 4'h0, 32'd8};
    vecs[10] = '{4'h2, 1'b0, 4'h2, 32'd9};
    vecs[11] = '{4'h4, 1'b0, 4'h4, 32'd10};
    vecs[12] = '{4'h5, 1'b0, 4'h1, 32'd11};
    vecs[13] = '{4'h5, 1'b0, 4'h4, 32'd12};
    vecs[14] = '{4'h8, 1'b0, 4'h8, 32'd13};
    vecs[15] = '{4'h8, 1'b0, 4'h8, 32'd14};
    vecs[16] = '{4'h0, 1'b0, 4'h0, 32'd14};
    g3 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    ls_tags = '{8'h0C, 8'h0A, 8'h09};

    flush = 1'b0; req4 = '0; req3 = '0;
    for (int i = 0; i < 4; i++) data4[i] = '{tag: {5'(i + 1), 3'b001}, val: 32'h0};
    for (int i = 0; i < 3; i++) data3[i] = '{tag: {5'(i + 1), 3'b010}, val: 32'h0};
    #1;
    do_reset();

    // Reset while a broadcast is on the bus, pointer back at 0 afterwards.
    req4 = 4'b0001; data4[0].tag = 8'h0C;
    tick();
    check("t1_pre_valid", 64'(cdb4.valid), 64'(1));
    do_reset();
    check("t1_valid", 64'(cdb4.valid), 64'(0));
    check("t1_cnt", 64'(cnt4), 64'(0));
    req4 = 4'b1111;
    tick();
    check("t1_ptr0", 64'(grant4), 64'(4'b0001));

    // Single source, then drop.
    do_reset();
    req4 = 4'b0001; data4[0] = '{tag: 8'h0C, val: 32'hDEADBEEF};
    tick();
    check("t2_cdb", 64'(cdb4), 64'({1'b1, 8'h0C, 32'hDEADBEEF}));
    check("t2_grant", 64'(grant4), 64'(4'b0001));
    req4 = 4'b0000;
    tick();
    check("t2_valid", 64'(cdb4.valid), 64'(0));
    check("t2_cnt", 64'(cnt4), 64'(1));

    // Vector table: round robin, idle, flush, wrap from ptr=3, back-to-back same source.
    do_reset();
    for (int r = 0; r < 17; r++) begin
      req4  = vecs[r].req;
      flush = vecs[r].fl;
      for (int i = 0; i < 4; i++) begin
        data4[i].tag = {5'(i + 1), 3'b001};
        data4[i].val = 32'hA000_0000 + 32'(r * 16 + i);
      end
      tick();
      check("tbl_gnt", 64'(grant4), 64'(vecs[r].gnt));
      check("tbl_cnt", 64'(cnt4), 64'(vecs[r].cnt));
      check("tbl_valid", 64'(cdb4.valid), 64'(vecs[r].gnt != 4'h0));
      if (vecs[r].gnt != 4'h0) begin
        check("tbl_val", 64'(cdb4.data), 64'(data4[$clog2(vecs[r].gnt)].val));
      end
    end
    flush = 1'b0;

    // Load/store unit: three loads retire on consecutive cycles with distinct RS tags.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      req4 = 4'b0001;
      data4[0] = '{tag: ls_tags[k], val: 32'h4000_0000 + 32'(k)};
      tick();
      check("ls_valid", 64'(cdb4.valid), 64'(1));
      check("ls_tag", 64'(cdb4.tag), 64'(ls_tags[k]));
    end
    req4 = 4'b0000;
    tick();
    check("ls_idle", 64'(cdb4.valid), 64'(0));
    check("ls_cnt", 64'(cnt4), 64'(3));

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      req4  = 4'($urandom);
      req3  = 3'($urandom);
      flush = ($urandom_range(7, 0) == 0);
      for (int i = 0; i < 4; i++) data4[i] = '{tag: rand_tag(), val: $urandom};
      for (int i = 0; i < 3; i++) data3[i] = '{tag: rand_tag(), val: $urandom};
      tick();
    end
    flush = 1'b0;

    // Three sources: wrap 0,1,2,0,... and 3-bit counter saturates at 7.
    do_reset();
    req3 = 3'b111;
    for (int i = 0; i < 3; i++) data3[i] = '{tag: {5'(i + 2), 3'b100}, val: 32'(i)};
    for (int k = 0; k < 8; k++) begin
      tick();
      check("wrap3", 64'(grant3), 64'(g3[k]));
    end
    check("sat3", 64'(cnt3), 64'(3'd7));
    req3 = 3'b000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
